// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - parametrised general/scratch register file with move path
// Optional read-port bypass of same-cycle writes: define RF_BYPASS_EN.

module reg_file_param #(
  parameter int WIDTH = 32,
  parameter int NREG  = 4,
  parameter int NSCR  = 4,
  parameter int SELW  = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] I,
  input  logic [2:0]       FunSel,
  input  logic [NREG-1:0]  RegSel,
  input  logic [NSCR-1:0]  ScrSel,
  input  logic             MovEn,
  input  logic [SELW-1:0]  MovSrc,
  input  logic [SELW-1:0]  OutASel,
  input  logic [SELW-1:0]  OutBSel,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB,
  output logic             ZeroA,
  output logic             ZeroB
);

  localparam int NTOT = NREG + NSCR;

  logic [WIDTH-1:0] q    [NTOT];
  logic [WIDTH-1:0] nxt  [NTOT];
  logic [WIDTH-1:0] view [NTOT];
  logic [NTOT-1:0]  en;
  logic [WIDTH-1:0] mov_val;

  // Flat index 0..NREG-1 = R1..R[NREG], then S1..S[NSCR]; select buses are MSB-first.
  for (genvar g = 0; g < NREG; g++) begin : g_reg_en
    assign en[g] = RegSel[NREG-1-g];
  end
  for (genvar g = 0; g < NSCR; g++) begin : g_scr_en
    assign en[NREG+g] = ScrSel[NSCR-1-g];
  end

  // Out-of-range move source matches no entry and yields zero.
  always_comb begin
    mov_val = '0;
    for (int k = 0; k < NTOT; k++) begin
      if (MovSrc == SELW'(k)) mov_val = q[k];
    end
  end

  always_comb begin
    for (int k = 0; k < NTOT; k++) begin
      nxt[k] = q[k];
      if (MovEn) begin
        nxt[k] = mov_val;
      end else begin
        case (FunSel)
          3'b000:  nxt[k] = q[k] - WIDTH'(1);
          3'b001:  nxt[k] = q[k] + WIDTH'(1);
          3'b010:  nxt[k] = I;
          3'b011:  nxt[k] = '0;
          3'b100:  nxt[k] = WIDTH'(I[7:0]);
          3'b101:  nxt[k] = WIDTH'(I[15:0]);
          3'b110:  nxt[k] = {q[k][WIDTH-9:0], I[7:0]};
          default: nxt[k] = WIDTH'($signed(I[15:0]));
        endcase
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int k = 0; k < NTOT; k++) q[k] <= '0;
    end else begin
      for (int k = 0; k < NTOT; k++) begin
        if (en[k]) q[k] <= nxt[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NTOT; k++) begin
`ifdef RF_BYPASS_EN
      // Reset dominates so the ports read zero while it is held.
      view[k] = (en[k] && !Reset) ? nxt[k] : q[k];
`else
      view[k] = q[k];
`endif
    end
  end

  always_comb begin
    OutA = '0;
    OutB = '0;
    for (int k = 0; k < NTOT; k++) begin
      if (OutASel == SELW'(k)) OutA = view[k];
      if (OutBSel == SELW'(k)) OutB = view[k];
    end
  end

  assign ZeroA = (OutA == '0);
  assign ZeroB = (OutB == '0);

endmodule

// File: tb/tb_reg_file_param.sv
// tb/tb_reg_file_param.sv - table-driven bench for reg_file_param (default 4+4 x 32)
// Same-cycle read expectation follows RF_BYPASS_EN.

module tb_reg_file_param;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [31:0] I;
  logic [2:0]  FunSel;
  logic [3:0]  RegSel;
  logic [3:0]  ScrSel;
  logic        MovEn;
  logic [3:0]  MovSrc;
  logic [3:0]  OutASel;
  logic [3:0]  OutBSel;
  logic [31:0] OutA;
  logic [31:0] OutB;
  logic        ZeroA;
  logic        ZeroB;

  int tests = 0;
  int fails = 0;

  reg_file_param #(.WIDTH(32), .NREG(4), .NSCR(4), .SELW(4)) dut (
    .Clock(Clock), .Reset(Reset), .I(I), .FunSel(FunSel), .RegSel(RegSel),
    .ScrSel(ScrSel), .MovEn(MovEn), .MovSrc(MovSrc), .OutASel(OutASel),
    .OutBSel(OutBSel), .OutA(OutA), .OutB(OutB), .ZeroA(ZeroA), .ZeroB(ZeroB)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [2:0]  f;
    logic [3:0]  rs;
    logic [3:0]  ss;
    logic        mv;
    logic [3:0]  src;
    logic [31:0] i;
    logic [3:0]  sa;
    logic [31:0] ea;
    logic [3:0]  sb;
    logic [31:0] eb;
  } vec_t;

  vec_t tbl [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    RegSel = 4'b0000;
    ScrSel = 4'b0000;
    MovEn  = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{3'b010, 4'b1000, 4'b0000, 1'b0, 4'd0,  32'h12345678, 4'd0, 32'h12345678, 4'd1, 32'h0};
    tbl[1]  = '{3'b110, 4'b1000, 4'b0000, 1'b0, 4'd0,  32'h000000AB, 4'd0, 32'h345678AB, 4'd4, 32'h0};
    tbl[2]  = '{3'b000, 4'b0100, 4'b0000, 1'b0, 4'd0,  32'h0,        4'd1, 32'hFFFFFFFF, 4'd0, 32'h345678AB};
    tbl[3]  = '{3'b001, 4'b0100, 4'b0000, 1'b0, 4'd0,  32'h0,        4'd1, 32'h0,        4'd0, 32'h345678AB};
    tbl[4]  = '{3'b111, 4'b0000, 4'b0101, 1'b0, 4'd0,  32'h00008001, 4'd5, 32'hFFFF8001, 4'd7, 32'hFFFF8001};
    tbl[5]  = '{3'b101, 4'b0000, 4'b0101, 1'b0, 4'd0,  32'hFFFF1234, 4'd5, 32'h00001234, 4'd4, 32'h0};
    tbl[6]  = '{3'b010, 4'b0010, 4'b0000, 1'b0, 4'd0,  32'h00000055, 4'd2, 32'h00000055, 4'd0, 32'h345678AB};
    tbl[7]  = '{3'b011, 4'b1001, 4'b0010, 1'b1, 4'd2,  32'hDEAD0000, 4'd0, 32'h00000055, 4'd6, 32'h00000055};
    tbl[8]  = '{3'b011, 4'b0000, 4'b0000, 1'b0, 4'd0,  32'h0,        4'd3, 32'h00000055, 4'd2, 32'h00000055};
    tbl[9]  = '{3'b010, 4'b1001, 4'b0010, 1'b1, 4'd15, 32'h00000012, 4'd3, 32'h0,        4'd6, 32'h0};
    tbl[10] = '{3'b010, 4'b0100, 4'b0000, 1'b0, 4'd0,  32'h00000099, 4'd1, 32'h00000099, 4'd0, 32'h0};
    tbl[11] = '{3'b000, 4'b0100, 4'b0000, 1'b1, 4'd1,  32'h0,        4'd1, 32'h00000099, 4'd5, 32'h00001234};
    tbl[12] = '{3'b100, 4'b0001, 4'b0000, 1'b0, 4'd0,  32'hFFFFFFC3, 4'd3, 32'h000000C3, 4'd9, 32'h0};
    tbl[13] = '{3'b010, 4'b0001, 4'b0000, 1'b0, 4'd0,  32'hFFFFFFFF, 4'd3, 32'hFFFFFFFF, 4'd0, 32'h0};
    tbl[14] = '{3'b001, 4'b0001, 4'b0000, 1'b0, 4'd0,  32'h0,        4'd3, 32'h0,        4'd2, 32'h00000055};
    tbl[15] = '{3'b001, 4'b0100, 4'b0100, 1'b0, 4'd0,  32'h0,        4'd1, 32'h0000009A, 4'd5, 32'h00001235};
    tbl[16] = '{3'b110, 4'b0000, 4'b0100, 1'b0, 4'd0,  32'h000000CD, 4'd5, 32'h001235CD, 4'd1, 32'h0000009A};

    Reset = 1'b1; I = '0; FunSel = 3'b010; MovSrc = '0;
    OutASel = 4'd0; OutBSel = 4'd7;
    idle();
    #1;
    check("reset_outa", OutA, 32'h0);
    check("reset_outb", OutB, 32'h0);
    check("reset_zeroa", {31'b0, ZeroA}, 32'h1);
    check("reset_zerob", {31'b0, ZeroB}, 32'h1);
    @(negedge Clock);
    Reset = 1'b0;

    for (int n = 0; n < 17; n++) begin
      @(negedge Clock);
      FunSel = tbl[n].f; RegSel = tbl[n].rs; ScrSel = tbl[n].ss;
      MovEn = tbl[n].mv; MovSrc = tbl[n].src; I = tbl[n].i;
      @(posedge Clock);
      #1;
      idle();
      OutASel = tbl[n].sa;
      OutBSel = tbl[n].sb;
      #1;
      check($sformatf("vec%0d_outa", n), OutA, tbl[n].ea);
      check($sformatf("vec%0d_outb", n), OutB, tbl[n].eb);
      check($sformatf("vec%0d_zeroa", n), {31'b0, ZeroA}, {31'b0, tbl[n].ea == 32'h0});
      check($sformatf("vec%0d_zerob", n), {31'b0, ZeroB}, {31'b0, tbl[n].eb == 32'h0});
    end

    // Same-cycle read of a register being written.
    @(negedge Clock);
    FunSel = 3'b010; I = 32'h11; RegSel = 4'b1000;
    @(posedge Clock);
    #1;
    idle();
    @(negedge Clock);
    OutASel = 4'd0; OutBSel = 4'd9;
    FunSel = 3'b010; I = 32'h77; RegSel = 4'b1000;
    #1;
`ifdef RF_BYPASS_EN
    check("same_cycle_outa", OutA, 32'h77);
`else
    check("same_cycle_outa", OutA, 32'h11);
`endif
    check("oor_outb", OutB, 32'h0);
    check("oor_zerob", {31'b0, ZeroB}, 32'h1);
    @(posedge Clock);
    #1;
    idle();
    #1;
    check("after_edge_outa", OutA, 32'h77);

    // Preload everything, then reset asynchronously mid-cycle.
    @(negedge Clock);
    FunSel = 3'b010; I = 32'hDEADBEEF; RegSel = 4'b1111; ScrSel = 4'b1111;
    @(posedge Clock);
    #1;
    idle();
    for (int k = 0; k < 8; k++) begin
      OutASel = 4'(k);
      #1;
      check($sformatf("preload_r%0d", k), OutA, 32'hDEADBEEF);
    end
    @(negedge Clock);
    #2;
    Reset = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      OutASel = 4'(k);
      OutBSel = 4'(7 - k);
      #0.1;
      check($sformatf("async_rst_a%0d", k), OutA, 32'h0);
      check($sformatf("async_rst_b%0d", k), OutB, 32'h0);
    end
    check("async_rst_zeroa", {31'b0, ZeroA}, 32'h1);
    check("async_rst_zerob", {31'b0, ZeroB}, 32'h1);

    // Edges are ignored while Reset is high; first edge after release writes.
    @(negedge Clock);
    OutASel = 4'd0; OutBSel = 4'd4;
    FunSel = 3'b010; I = 32'h1; RegSel = 4'b1000; ScrSel = 4'b1000;
    @(posedge Clock);
    #1;
    check("rst_hold_outa", OutA, 32'h0);
    check("rst_hold_outb", OutB, 32'h0);
    @(negedge Clock);
    Reset = 1'b0;
    @(posedge Clock);
    #1;
    idle();
    #1;
    check("post_rst_write_a", OutA, 32'h1);
    check("post_rst_write_b", OutB, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
